// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared definitions for the memory-backed FIFO controller.
// Contents: default widths/depth, memory access direction constants,
// and the per-cycle memory access kind chosen by the arbiter.
package mem_fifo_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Memory wr pin encoding
    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    // One memory access per cycle: nothing, a read or a write
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_WRITE
    } acc_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer for the FIFO memory.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset, clears the pointer
//   inc   in   advance the pointer by one at the next edge
//   ptr   out  current pointer, wraps modulo 2**ADDR_W
module fifo_ptr #(
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous memory.
// Pushes are written into the memory; the head is read back into a
// one-entry output register presented on the pop port. One memory
// access per cycle, reads take priority over writes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   push_valid/ready/data   producer side handshake
//   pop_valid/ready/data    consumer side handshake, pop_data registered
//   count                   words held (memory + read in flight + out reg)
//   full, empty             memory full / nothing held
//   address, wr, mem_in     memory request
//   mem_out                 memory read data (one cycle after the read)
module mem_fifo_ctrl
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] address,
    output logic              wr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              rd_pend;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem_in_q;
    logic              rd_go;
    logic              wr_go;
    acc_e              acc;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_go),
        .ptr   (wptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_go),
        .ptr   (rptr)
    );

    // A read may start only when the output register will be free by the
    // time its data returns; at most one read is in flight.
    always_comb begin
        rd_go      = (mem_cnt != '0) && !rd_pend && (!pop_valid || pop_ready);
        push_ready = (mem_cnt < DEPTH_C) && !rd_go;
        wr_go      = push_valid && push_ready;

        acc = ACC_IDLE;
        if (rd_go) begin
            acc = ACC_READ;
        end else if (wr_go) begin
            acc = ACC_WRITE;
        end

        // Idle cycles keep the previous address/data on the memory bus
        wr      = RD;
        address = addr_q;
        mem_in  = mem_in_q;
        case (acc)
            ACC_READ: begin
                address = rptr;
            end
            ACC_WRITE: begin
                wr      = WR;
                address = wptr;
                mem_in  = push_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt   <= '0;
            rd_pend   <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            addr_q    <= '0;
            mem_in_q  <= '0;
        end else begin
            addr_q   <= address;
            mem_in_q <= mem_in;
            rd_pend  <= rd_go;

            // rd_go and wr_go are mutually exclusive
            if (rd_go) begin
                mem_cnt <= mem_cnt - 1'b1;
            end else if (wr_go) begin
                mem_cnt <= mem_cnt + 1'b1;
            end

            // Returning read data wins over a pop in the same cycle
            if (rd_pend) begin
                pop_valid <= 1'b1;
                pop_data  <= mem_out;
            end else if (pop_valid && pop_ready) begin
                pop_valid <= 1'b0;
            end
        end
    end

    // pop_valid is always 0 while a read is in flight, so the sum fits
    always_comb begin
        count = mem_cnt + {{ADDR_W{1'b0}}, rd_pend} + {{ADDR_W{1'b0}}, pop_valid};
        full  = (mem_cnt == DEPTH_C);
        empty = (count == '0);
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
module tb_mem_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic [3:0] push_data = '0;
    logic       pop_valid;
    logic       pop_ready = 1'b0;
    logic [3:0] pop_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic [1:0] address;
    logic       wr;
    logic [3:0] mem_in;
    logic [3:0] mem_out = '0;

    logic [3:0] mem [4];

    int n_cmp = 0;
    int n_err = 0;
    int wcnt_m = 0;
    int wtot = 0;
    logic [3:0] sb[$];
    logic [3:0] e;

    mem_fifo_ctrl #(.DATA_W(4), .ADDR_W(2), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .address    (address),
        .wr         (wr),
        .mem_in     (mem_in),
        .mem_out    (mem_out)
    );

    always #10 clk = ~clk;

    // 4x4 single-port memory: write or 1-cycle registered read
    always @(posedge clk) begin
        if (wr) mem[address] <= mem_in;
        else    mem_out <= mem[address];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle; handshakes take effect at the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            wcnt_m = 0;
        end else begin
            chk("count", int'(count), sb.size());
            chk("empty", int'(empty), int'(sb.size() == 0));
            chk("wr_vs_push", int'(wr), int'(push_valid && push_ready));
            if (full) chk("full_push_ready", int'(push_ready), 0);
            if (wr) begin
                chk("wr_addr", int'(address), wcnt_m % 4);
                chk("wr_data", int'(mem_in), int'(push_data));
            end
            if (pop_valid && pop_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_unexpected: got data %0d expected no word at %0t", pop_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("pop_data", int'(pop_data), int'(e));
                end
            end
            if (push_valid && push_ready) begin
                sb.push_back(push_data);
                wcnt_m++;
                wtot++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [3:0] d);
        push_valid = 1'b1;
        push_data  = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (push_ready) begin
                cyc();
                push_valid = 1'b0;
                return;
            end
            cyc();
        end
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: got no push_ready expected acceptance of %0d", d);
        push_valid = 1'b0;
    endtask

    task automatic drain();
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (count == 0) begin
                cyc();
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: got count %0d expected 0", count);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_pop_data", int'(pop_data), 0);
        chk("rst_wr", int'(wr), 0);
        chk("rst_address", int'(address), 0);
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();

        // Single word latency
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        push_data  = 4'hA;
        @(negedge clk);
        chk("lat_t_wr", int'(wr), 1);
        chk("lat_t_addr", int'(address), 0);
        cyc();
        push_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_wr", int'(wr), 0);
        chk("lat_t1_addr", int'(address), 0);
        chk("lat_t1_pop_valid", int'(pop_valid), 0);
        @(negedge clk);
        chk("lat_t2_pop_valid", int'(pop_valid), 0);
        @(negedge clk);
        chk("lat_t3_pop_valid", int'(pop_valid), 1);
        chk("lat_t3_pop_data", int'(pop_data), 10);
        cyc();
        @(negedge clk);
        chk("lat_after_empty", int'(empty), 1);
        cyc();

        // Fill with consumer stalled
        pop_ready = 1'b0;
        push_word(4'hF);
        push_word(4'h3);
        push_word(4'hC);
        push_word(4'h0);
        push_word(4'h5);
        @(negedge clk);
        chk("fill_count", int'(count), 5);
        chk("fill_full", int'(full), 1);
        chk("fill_push_ready", int'(push_ready), 0);
        chk("fill_pop_valid", int'(pop_valid), 1);
        chk("fill_head", int'(pop_data), 15);
        cyc();
        push_valid = 1'b1;
        push_data  = 4'h7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold6_push_ready", int'(push_ready), 0);
            chk("hold6_count", int'(count), 5);
            cyc();
        end

        // Drain; the held 6th word goes in once space frees
        pop_ready = 1'b1;
        push_word(4'h7);
        drain();
        @(negedge clk);
        chk("drain_empty", int'(empty), 1);
        cyc();

        // Reset with a read in flight
        pop_ready = 1'b0;
        push_word(4'h1);
        push_word(4'h2);
        pop_ready = 1'b1;
        cyc();
        rst_n      = 1'b0;
        pop_ready  = 1'b1;
        @(negedge clk);
        chk("mrst_count", int'(count), 0);
        chk("mrst_empty", int'(empty), 1);
        chk("mrst_pop_valid", int'(pop_valid), 0);
        chk("mrst_wr", int'(wr), 0);
        chk("mrst_address", int'(address), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mrst_no_stale", int'(pop_valid), 0);
            cyc();
        end

        // Random interleaving across pointer wraps
        wtot = 0;
        for (int i = 0; i < 120; i++) begin
            push_valid = 1'($urandom_range(0, 1));
            push_data  = 4'($urandom);
            pop_ready  = 1'($urandom_range(0, 1));
            cyc();
        end
        drain();
        chk("wrap_enough_pushes", int'(wtot >= 10), 1);

        // Continuous push while reads are due
        for (int i = 0; i < 40; i++) begin
            push_valid = 1'b1;
            push_data  = 4'($urandom);
            pop_ready  = 1'b1;
            cyc();
        end
        drain();
        @(negedge clk);
        chk("final_empty", int'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
